instr_fetch: RTL
================

Name: instr_fetch

Overview:
- Instruction fetch stage placed directly downstream of the PC register.
- Consumes the current `pc` and drives the `pc_next` that the PC register loads every cycle: hold, +4, or redirect target.
- Issues in-order word requests to instruction memory and buffers up to 2 returned instructions.
- Presents instructions to decode over a valid/ready handshake; discards stale responses after a redirect.

Parameters:
- RST_PC_ADDRESS, 32'h0, value driven on pc_next while rst is high; matches the PC register reset address.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-high
- pc  input  32  current program counter from the PC register
- pc_next  output  32  next PC, registered by the PC register every cycle
- redirect_valid  input  1  branch/jump/trap redirect, single-cycle pulse
- redirect_pc  input  32  redirect target
- imem_req_valid  output  1  instruction memory request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  32  request address (= pc)
- imem_rsp_valid  input  1  response valid; in order, ≥1 cycle after acceptance, no backpressure
- imem_rsp_data  input  32  instruction word
- inst_valid  output  1  instruction available to decode
- inst_ready  input  1  decode accepts
- inst_data  output  32  instruction word
- inst_pc  output  32  PC of inst_data
- inst_fault  output  1  misaligned-fetch fault flag for this entry

Behaviour:
- Internal state:
  - pc_q: 2-entry queue of PCs of accepted, unanswered requests.
  - out_q: 2-entry FIFO of {pc, data, fault}.
  - drop_cnt: 0..2.
  - halted: set by a fault entry.
- Credit rule: `credit = (pc_q count + out_q count + drop_cnt) < 2`.
- Request issue:
  - `imem_req_valid = !rst & !redirect_valid & !halted & credit & (pc[1:0]==0)`.
  - `imem_req_addr = pc`.
  - Handshake = imem_req_valid & imem_req_ready; on handshake, pc is pushed to pc_q.
  - Valid/addr stay stable until handshake. The only exception is redirect, which may withdraw a pending request.
- pc_next priority:
  1. rst → RST_PC_ADDRESS
  2. redirect_valid → redirect_pc
  3. handshake → pc+4, wrapping modulo 2^32 (32'hFFFFFFFC+4 = 0)
  4. else → pc
- Misaligned pc (`pc[1:0]!=0`), with !halted, credit, !redirect_valid and pc_q empty:
  - No memory request is issued.
  - Push {pc, 32'h0, 1} to out_q and set halted; pc_next = pc.
  - halted clears only on redirect or rst.
- Response handling:
  - If drop_cnt>0: decrement drop_cnt and discard the response.
  - Else: pop pc_q and push {popped pc, imem_rsp_data, 0} to out_q.
  - A response with pc_q empty and drop_cnt==0 is illegal (simulation assertion).
- Output:
  - inst_valid = out_q non-empty; inst_data / inst_pc / inst_fault come from the head entry, are combinational from registers, and stay stable while valid & !ready.
  - Pop on inst_valid & inst_ready.
  - Push and pop in the same cycle is legal at any occupancy, including full.
- Redirect, in its cycle:
  - out_q is flushed and halted cleared.
  - drop_cnt takes pc_q count.
  - If a response arrives in that same cycle, it consumes one of those drops: drop_cnt takes pc_q count − 1, floored at 0.
  - pc_q is cleared and no request is issued.
  - An inst pop in the same cycle is ignored: the flush wins.
  - Fetch resumes the next cycle at redirect_pc.
- Latency:
  - Request issues in the same cycle pc is presented, if credit allows.
  - Response is visible on inst_valid one cycle after imem_rsp_valid (registered FIFO).
- Reset (synchronous, rst high at posedge):
  - Queues and drop_cnt cleared; halted=0.
  - inst_valid=0, imem_req_valid=0, pc_next=RST_PC_ADDRESS.
  - Reset mid-operation discards in-flight responses: the memory side is reset together with the core, so no post-reset responses arrive.
- Throughput: with 1-cycle memory latency and inst_ready held high, one instruction per cycle sustained.

Test Plan:
- Reset release, RST_PC_ADDRESS=0, memory ready always, 1-cycle latency, inst_ready=1 → requests at 0,4,8,…; inst_valid from cycle 2 on, one per cycle, inst_pc 0,4,8 with matching data.
- inst_ready held 0 → at most 2 requests accepted; imem_req_valid drops; pc_next stays 8. Release ready → entries 0,4 delivered in order, fetch resumes at 8.
- Two requests outstanding (pcs 0x10, 0x14), redirect_pc=0x200 → both responses discarded; next delivered inst_pc=0x200; nothing from 0x10/0x14 reaches decode.
- Redirect in the same cycle a response arrives with 2 outstanding → that response and exactly one more are dropped; no instruction delivered until the 0x200 response.
- redirect_pc=0x102 → no memory request; inst_fault=1, inst_pc=0x102, data 0; fetch stays halted until redirect_pc=0x100, then normal fetch at 0x100.
- pc=32'hFFFFFFFC request accepted → pc_next=0. rst asserted mid-stream with entries buffered → next cycle inst_valid=0, imem_req_valid=0, pc_next=RST_PC_ADDRESS.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives pc_next, issues in-order word requests,
// buffers up to two returned instructions and drops stale ones after a redirect.
module instr_fetch #(
  parameter logic [31:0] RST_PC_ADDRESS = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] pc_next,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        inst_fault
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic        fault;
  } entry_t;

  logic [31:0] pcq_mem [2];
  logic        pcq_rp, pcq_wp;
  logic [1:0]  pcq_cnt;

  entry_t      out_mem [2];
  logic        out_rp, out_wp;
  logic [1:0]  out_cnt;

  logic [1:0]  drop_cnt;
  logic        halted;

  logic        aligned, inst_pop, credit, fetch_ok;
  logic        fault_push, hs, rsp_take, rsp_drop, out_push;
  logic [2:0]  occ;
  logic [1:0]  rsum, redir_drop;
  entry_t      out_new, head;

  // An entry leaving for decode this cycle frees its slot for a new request,
  // which is what lets 1-cycle memory sustain one instruction per cycle.
  always_comb begin
    aligned  = pc[1:0] == 2'b00;
    inst_pop = inst_valid & inst_ready;
    occ      = {1'b0, pcq_cnt} + {1'b0, out_cnt} + {1'b0, drop_cnt}
             - {2'b00, inst_pop};
    credit   = occ < 3'd2;
    fetch_ok = !rst & !redirect_valid & !halted & credit;

    imem_req_valid = fetch_ok & aligned;
    imem_req_addr  = pc;
    fault_push     = fetch_ok & !aligned & (pcq_cnt == 2'd0);
    hs             = imem_req_valid & imem_req_ready;

    rsp_drop = imem_rsp_valid & (drop_cnt != 2'd0);
    rsp_take = imem_rsp_valid & (drop_cnt == 2'd0)
             & !redirect_valid & !rst;
    out_push = rsp_take | fault_push;

    if (fault_push)
      out_new = '{pc: pc, data: 32'h0, fault: 1'b1};
    else
      out_new = '{pc: pcq_mem[pcq_rp], data: imem_rsp_data, fault: 1'b0};

    // Responses still in flight after a redirect must all be discarded.
    rsum       = drop_cnt + pcq_cnt;
    redir_drop = (imem_rsp_valid && rsum != 2'd0) ? rsum - 2'd1 : rsum;

    if (rst)
      pc_next = RST_PC_ADDRESS;
    else if (redirect_valid)
      pc_next = redirect_pc;
    else if (hs)
      pc_next = pc + 32'd4;
    else
      pc_next = pc;
  end

  assign head       = out_mem[out_rp];
  assign inst_valid = out_cnt != 2'd0;
  assign inst_data  = head.data;
  assign inst_pc    = head.pc;
  assign inst_fault = head.fault;

  always_ff @(posedge clk) begin
    if (rst) begin
      pcq_rp   <= 1'b0;
      pcq_wp   <= 1'b0;
      pcq_cnt  <= 2'd0;
      out_rp   <= 1'b0;
      out_wp   <= 1'b0;
      out_cnt  <= 2'd0;
      drop_cnt <= 2'd0;
      halted   <= 1'b0;
    end else if (redirect_valid) begin
      pcq_cnt  <= 2'd0;
      pcq_rp   <= pcq_wp;
      out_cnt  <= 2'd0;
      out_rp   <= out_wp;
      halted   <= 1'b0;
      drop_cnt <= redir_drop;
    end else begin
      if (hs)       pcq_wp <= ~pcq_wp;
      if (rsp_take) pcq_rp <= ~pcq_rp;
      pcq_cnt <= pcq_cnt + {1'b0, hs} - {1'b0, rsp_take};
      if (out_push) out_wp <= ~out_wp;
      if (inst_pop) out_rp <= ~out_rp;
      out_cnt <= out_cnt + {1'b0, out_push} - {1'b0, inst_pop};
      if (rsp_drop)   drop_cnt <= drop_cnt - 2'd1;
      if (fault_push) halted   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (hs)       pcq_mem[pcq_wp] <= pc;
    if (out_push) out_mem[out_wp] <= out_new;
  end

  // A response must always belong to an outstanding or dropped request.
  always_ff @(posedge clk) begin
    if (!rst)
      assert (!(imem_rsp_valid && pcq_cnt == 2'd0 && drop_cnt == 2'd0));
  end

endmodule
